// File: rtl/sr_ctrl_pkg.sv
// Shared definitions for the serial configuration register access controller.
// One-hot state encoding and default register length.
package sr_ctrl_pkg;

    localparam int SR_DATA_WIDTH = 170;

    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        LO   = 5'b00010,
        HI   = 5'b00100,
        LOAD = 5'b01000,
        DONE = 5'b10000
    } sr_state_e;

endpackage

// File: rtl/sr_phase_div.sv
// Half-period timer for sr_clk: latches the divider on load and flags
// the last clk cycle of every half-period.
module sr_phase_div
    import sr_ctrl_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 clear,
    output logic                 phase_end
);

    logic [DIV_WIDTH-1:0] d_q;
    logic [DIV_WIDTH-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= '0;
            cnt <= '0;
        end else begin
            // A zero divider behaves exactly like a divider of one
            if (load) begin
                d_q <= (div == '0) ? DIV_WIDTH'(1) : div;
            end
            if (clear || phase_end) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DIV_WIDTH'(1);
            end
        end
    end

    assign phase_end = (cnt == d_q - DIV_WIDTH'(1));

endmodule

// File: rtl/sr_access_ctrl.sv
// Runs one full write/readback access of the chip's serial config register:
// shift out din, capture old contents, pulse sr_load, present dout with done.
module sr_access_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH      = SR_DATA_WIDTH,
    parameter int CNT_WIDTH       = 8,
    parameter int DIV_WIDTH       = 8,
    parameter int SHIFT_DIRECTION = 1,
    parameter int LOAD_CYCLES     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [DIV_WIDTH-1:0]  div,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  sr_clk,
    output logic                  sr_din,
    input  logic                  sr_dout,
    output logic                  sr_load
);

    localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [LW-1:0] LAST_LOAD = LW'(LOAD_CYCLES - 1);

    sr_state_e             state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_nxt;
    logic [DATA_WIDTH-1:0] cap;
    logic [DATA_WIDTH-1:0] cap_nxt;
    logic [CNT_WIDTH-1:0]  bit_cnt;
    logic [LW-1:0]         load_cnt;
    logic                  din_lead;
    logic                  nxt_lead;
    logic                  accept;
    logic                  phase_clr;
    logic                  phase_end;

    assign accept    = (state == IDLE) && start;
    assign phase_clr = (state != LO) && (state != HI);

    always_comb begin
        shreg_nxt = shreg;
        cap_nxt   = cap;
        din_lead  = 1'b0;
        nxt_lead  = 1'b0;
        if (SHIFT_DIRECTION != 0) begin
            shreg_nxt = shreg << 1;
            cap_nxt   = {cap[DATA_WIDTH-2:0], sr_dout};
            din_lead  = din[DATA_WIDTH-1];
            nxt_lead  = shreg_nxt[DATA_WIDTH-1];
        end else begin
            shreg_nxt = shreg >> 1;
            cap_nxt   = {sr_dout, cap[DATA_WIDTH-1:1]};
            din_lead  = din[0];
            nxt_lead  = shreg_nxt[0];
        end
    end

    sr_phase_div #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_phase_div (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .div       (div),
        .clear     (phase_clr),
        .phase_end (phase_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            cap      <= '0;
            bit_cnt  <= '0;
            load_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dout     <= '0;
            sr_clk   <= 1'b0;
            sr_din   <= 1'b0;
            sr_load  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LO;
                        shreg   <= din;
                        cap     <= '0;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        sr_clk  <= 1'b0;
                        sr_din  <= din_lead;
                    end
                end
                LO: begin
                    if (phase_end) begin
                        state  <= HI;
                        sr_clk <= 1'b1;
                    end
                end
                HI: begin
                    // Chip output is sampled on the edge that drops sr_clk
                    if (phase_end) begin
                        cap     <= cap_nxt;
                        bit_cnt <= bit_cnt + CNT_WIDTH'(1);
                        sr_clk  <= 1'b0;
                        if (bit_cnt == LAST_BIT) begin
                            state    <= LOAD;
                            sr_din   <= 1'b0;
                            sr_load  <= 1'b1;
                            load_cnt <= '0;
                        end else begin
                            state  <= LO;
                            shreg  <= shreg_nxt;
                            sr_din <= nxt_lead;
                        end
                    end
                end
                LOAD: begin
                    if (load_cnt == LAST_LOAD) begin
                        state   <= DONE;
                        sr_load <= 1'b0;
                        dout    <= cap;
                        done    <= 1'b1;
                    end else begin
                        load_cnt <= load_cnt + LW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_access_ctrl.sv
// Bench for sr_access_ctrl: MSB-first and LSB-first instances share stimulus,
// each talking to a behavioural chip shift register.
module tb_sr_access_ctrl;

    localparam int W  = 8;
    localparam int LC = 2;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] din;
    logic [7:0]   div;

    logic         busy_a, done_a, sclk_a, sdin_a, sdout_a, sload_a;
    logic         busy_b, done_b, sclk_b, sdin_b, sdout_b, sload_b;
    logic [W-1:0] dout_a, dout_b;

    sr_access_ctrl #(
        .DATA_WIDTH      (W),
        .CNT_WIDTH       (8),
        .DIV_WIDTH       (8),
        .SHIFT_DIRECTION (1),
        .LOAD_CYCLES     (LC)
    ) dut_a (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .din     (din),
        .div     (div),
        .busy    (busy_a),
        .done    (done_a),
        .dout    (dout_a),
        .sr_clk  (sclk_a),
        .sr_din  (sdin_a),
        .sr_dout (sdout_a),
        .sr_load (sload_a)
    );

    sr_access_ctrl #(
        .DATA_WIDTH      (W),
        .CNT_WIDTH       (8),
        .DIV_WIDTH       (8),
        .SHIFT_DIRECTION (0),
        .LOAD_CYCLES     (LC)
    ) dut_b (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .din     (din),
        .div     (div),
        .busy    (busy_b),
        .done    (done_b),
        .dout    (dout_b),
        .sr_clk  (sclk_b),
        .sr_din  (sdin_b),
        .sr_dout (sdout_b),
        .sr_load (sload_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Chip: takes data on sr_clk rise, shifts on fall, latches when sr_load ends
    logic [W-1:0] chip_a = 8'h3C;
    logic [W-1:0] chip_b = 8'h3C;
    logic [W-1:0] lat_a  = 8'h00;
    logic [W-1:0] lat_b  = 8'h00;
    logic         in_a   = 1'b0;
    logic         in_b   = 1'b0;

    always @(posedge sclk_a) in_a = sdin_a;
    always @(posedge sclk_b) in_b = sdin_b;
    always @(negedge sclk_a) if (!rst) chip_a = {chip_a[W-2:0], in_a};
    always @(negedge sclk_b) if (!rst) chip_b = {in_b, chip_b[W-1:1]};
    always @(negedge sload_a) if (!rst) lat_a = chip_a;
    always @(negedge sload_b) if (!rst) lat_b = chip_b;
    assign sdout_a = chip_a[W-1];
    assign sdout_b = chip_b[0];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [W-1:0] prev_word = 8'h3C;
    bit           prev_ok   = 1'b1;

    // Caller is #1 into a cycle; start is sampled at the next edge (cycle 0)
    task automatic access(input logic [W-1:0] d, input logic [7:0] v,
                          input bit hold, input bit intrude);
        int           dd, lim, rises, first_rise, load_n, done_at;
        int           gaps, skew;
        logic         prev_clk;
        logic [W-1:0] snap_a, snap_b, seq_a, seq_b;
        dd     = (v == 0) ? 1 : int'(v);
        lim    = 2 * dd * W + LC + 8;
        snap_a = chip_a;
        snap_b = chip_b;
        start  = 1'b1;
        din    = d;
        div    = v;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        din = W'($urandom);
        div = 8'($urandom);
        rises = 0; first_rise = 0; load_n = 0; done_at = 0;
        gaps = 0; skew = 0; prev_clk = 1'b0;
        seq_a = '0; seq_b = '0;
        for (int k = 1; k <= lim && done_at == 0; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            if (intrude && k == 5) begin
                start = 1'b1;
                din   = 8'hFF;
            end else if (intrude && k == 6 && !hold) begin
                start = 1'b0;
            end
            if (!busy_a || !busy_b) gaps++;
            if (sclk_a && !prev_clk) begin
                if (rises == 0) first_rise = k;
                if (rises < W) begin
                    seq_a[W-1-rises] = sdin_a;
                    seq_b[rises]     = sdin_b;
                end
                rises++;
            end
            prev_clk = sclk_a;
            if (sclk_a !== sclk_b || done_a !== done_b || sload_a !== sload_b)
                skew++;
            if (sload_a) load_n++;
            if (done_a) done_at = k;
        end
        chk("done_cycle", done_at, 2 * dd * W + LC + 1);
        chk("first_rise", first_rise, dd + 1);
        chk("rise_count", rises, W);
        chk("load_cycles", load_n, LC);
        chk("busy_gap", gaps, 0);
        chk("inst_skew", skew, 0);
        chk("sdin_msb_first", seq_a, d);
        chk("sdin_lsb_first", seq_b, d);
        chk("dout_a_chip", dout_a, snap_a);
        chk("dout_b_chip", dout_b, snap_b);
        if (prev_ok) begin
            chk("dout_a_prev", dout_a, prev_word);
            chk("dout_b_prev", dout_b, prev_word);
        end
        @(posedge clk);
        #1;
        chk("after_done", {busy_a, done_a, busy_b, done_b}, 0);
        chk("latch_a", lat_a, d);
        chk("latch_b", lat_b, d);
        prev_word = d;
        prev_ok   = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] la, lb;
        int           loads;
        bit           last_hold;
        rst   = 1'b1;
        start = 1'b0;
        din   = '0;
        div   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctl", {busy_a, done_a, sclk_a, sdin_a, sload_a,
                          busy_b, done_b, sclk_b, sdin_b, sload_b}, 0);
        chk("reset_dout", {dout_a, dout_b}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        access(8'hA5, 8'd1, 1'b0, 1'b0);
        access(8'h5A, 8'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        access(8'hC3, 8'd3, 1'b0, 1'b1);
        access(8'h96, 8'd1, 1'b1, 1'b0);
        access(8'h69, 8'd2, 1'b1, 1'b1);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("no_queued", {busy_a, busy_b}, 0);

        // Abort in cycle 7 of an access
        la    = lat_a;
        lb    = lat_b;
        start = 1'b1;
        din   = 8'hE1;
        div   = 8'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        chk("abort_ctl", {busy_a, done_a, sclk_a, sdin_a, sload_a,
                          busy_b, done_b, sclk_b, sdin_b, sload_b}, 0);
        chk("abort_dout", {dout_a, dout_b}, 0);
        loads = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (sload_a || sload_b) loads++;
        end
        rst = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (sload_a || sload_b || busy_a || busy_b) loads++;
        end
        chk("abort_no_load", loads, 0);
        chk("abort_latch", {lat_a, lat_b}, {la, lb});
        prev_ok = 1'b0;

        last_hold = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bit h, x;
            h = bit'($urandom_range(0, 1));
            x = bit'($urandom_range(0, 1));
            if (!last_hold) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            access(W'($urandom), 8'($urandom_range(0, 3)), h, x);
            last_hold = h;
        end
        start = 1'b0;
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sr_access_ctrl.md
Name: sr_access_ctrl

Overview:
- Sequences one complete access to the chip's serial configuration shift register.
- Serializes a parallel word onto sr_din with a generated sr_clk. Simultaneously captures the old contents shifted out on sr_dout.
- Pulses sr_load to latch the new word, then presents the readback word with a done strobe.
- Sits between the host register bank and the chip pads. It replaces ad-hoc start sequencing of the separate serializer and receiver.

Parameters:
- DATA_WIDTH, 170, shift register length in bits.
- CNT_WIDTH, 8, bit counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.
- DIV_WIDTH, 8, width of the sr_clk half-period control.
- SHIFT_DIRECTION, 1, 1: MSB shifted out first and first bit in lands in MSB; 0: LSB first and first bit in lands in LSB.
- LOAD_CYCLES, 2, width of the sr_load pulse in clk cycles (>=1).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request an access; sampled only in IDLE.
- din  in  DATA_WIDTH  word to write; latched on accepted start.
- div  in  DIV_WIDTH  sr_clk half-period in clk cycles; latched on start; 0 treated as 1.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle pulse when dout is updated.
- dout  out  DATA_WIDTH  captured previous contents of the chip register.
- sr_clk  out  1  shift clock to chip.
- sr_din  out  1  serial data to chip.
- sr_dout  in  1  serial data from chip.
- sr_load  out  1  latch strobe to chip.

Behaviour:
- Reset values: busy=0, done=0, dout=0, sr_clk=0, sr_din=0, sr_load=0, state=IDLE, counters=0.
- Reset mid-access aborts immediately, with no partial load and dout unchanged from 0.
- Let D = max(div,1) and W = DATA_WIDTH.
- IDLE: outputs idle. start=1 at cycle 0 → latch din into the shift reg and D into a register; go to LO; clear the bit count and capture reg.
- LO (D cycles):
  - sr_clk=0.
  - sr_din presents bit n from the entry edge; n=0 is the MSB when SHIFT_DIRECTION=1.
  - At phase-count end → HI.
- HI (D cycles):
  - sr_clk=1; sr_din held.
  - On the clk edge ending the last HI cycle, sample sr_dout into capture position n; n increments.
  - If n becomes W → LOAD; else → LO, and the shift reg advances so sr_din shows bit n+1.
- LOAD (LOAD_CYCLES cycles): sr_clk=0, sr_load=1, sr_din=0.
- DONE (1 cycle): dout=capture reg (registered on the entry edge), done=1, busy=1. Then IDLE with busy=0.
- Latency: cycles are counted with the start-sampling edge as cycle 0.
  - First sr_clk rise at cycle D+1.
  - Exactly W sr_clk rising edges per access.
  - done is high in cycle 2·D·W + LOAD_CYCLES + 1.
- start while busy is ignored; it is not queued.
- start held high continuously → back-to-back accesses with one IDLE cycle between them.
- din/div changes after acceptance have no effect.
- sr_clk, sr_din and sr_load are driven straight from flops, with no combinational output paths.
- The bit counter never exceeds W; the phase counter wraps at D-1.

Decomposition:
- Shared package sr_ctrl_pkg holds:
  - state encodings IDLE/LO/HI/LOAD/DONE (one-hot, 5 bits);
  - the default DATA_WIDTH (170).
- One natural sub-module, sr_phase_div: a phase counter with a latched D that emits phase_end on the last cycle of each half-period. It restarts on a state change.
- The bit-capture logic stays inline.

Test Plan:
- DATA_WIDTH=8, div=1, LOAD_CYCLES=2, din=8'hA5; the chip model is a preloaded 8'h3C register. Start → sr_din sequence 1,0,1,0,0,1,0,1 on the 8 sr_clk rises. done in cycle 19, dout=8'h3C, model register=8'hA5 after sr_load.
- Same setup with SHIFT_DIRECTION=0 → LSB-first sr_din 1,0,1,0,0,1,0,1 reversed order; dout=8'h3C; done in cycle 19.
- div=0 vs div=1 → identical timing; div=3 → sr_clk high/low 3 cycles each, done in cycle 51, busy high cycles 1–51.
- start pulsed at cycle 5 during an access with din=8'hFF → ignored. A second access with start held high begins one cycle after done, and its dout equals the first access's din.
- rst asserted at cycle 7 mid-shift → all outputs 0 in that cycle, no sr_load pulse, dout=0. A subsequent start completes normally.
- Default DATA_WIDTH=170, div=1, random din twice → second dout equals first din, done in cycle 343, exactly 170 sr_clk rises per access.
